// File: rtl/tbcm_rr_arbiter.sv
// Round-robin arbiter producing a registered one-hot select for tbcm_mux.
// Optional binary index output enabled by defining TBCM_RR_ARBITER_INDEX_EN.
module tbcm_rr_arbiter #(
  parameter int unsigned ENTRIES = 2,
  localparam int unsigned INDEX_WIDTH = $clog2(ENTRIES)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [ENTRIES-1:0]     i_request,
  input  logic                   i_free,
  output logic [ENTRIES-1:0]     o_grant,
  output logic                   o_valid
`ifdef TBCM_RR_ARBITER_INDEX_EN
  ,
  output logic [INDEX_WIDTH-1:0] o_index
`endif
);

  typedef enum logic {
    IDLE,
    GRANTED
  } state_t;

  state_t                 state_q, state_d;
  logic [ENTRIES-1:0]     grant_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [INDEX_WIDTH-1:0] cur_idx;
  logic [INDEX_WIDTH-1:0] free_ptr;
  logic                   releasing;
  logic [INDEX_WIDTH-1:0] scan_start;
  logic [ENTRIES-1:0]     scan_req;
  logic                   win_found;
  logic [INDEX_WIDTH-1:0] win_idx;
  logic [ENTRIES-1:0]     win_onehot;

  always_comb begin
    cur_idx = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (o_grant[i]) cur_idx = INDEX_WIDTH'(i);
    end
  end

  assign free_ptr = INDEX_WIDTH'((32'(cur_idx) + 32'd1) % ENTRIES);

  // On release the scan starts past the current winner and excludes it,
  // so the freed requester only wins again when nobody else is asking.
  always_comb begin
    releasing  = (state_q == GRANTED) && i_free;
    scan_start = releasing ? free_ptr : ptr_q;
    scan_req   = releasing ? (i_request & ~o_grant) : i_request;
  end

  always_comb begin
    int unsigned pos;
    pos        = 0;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      pos = (32'(scan_start) + i) % ENTRIES;
      if (!win_found && scan_req[pos]) begin
        win_found = 1'b1;
        win_idx   = INDEX_WIDTH'(pos);
      end
    end
    if (win_found) win_onehot[win_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = o_grant;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (win_found) begin
          grant_d = win_onehot;
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (i_free) begin
          ptr_d = free_ptr;
          if (win_found) begin
            grant_d = win_onehot;
          end else if ((i_request & o_grant) != '0) begin
            grant_d = o_grant;
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      o_grant <= '0;
      o_valid <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      o_grant <= grant_d;
      o_valid <= |grant_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef TBCM_RR_ARBITER_INDEX_EN
  logic [INDEX_WIDTH-1:0] index_d;

  always_comb begin
    index_d = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (grant_d[i]) index_d = INDEX_WIDTH'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_index <= '0;
    end else if (|grant_d) begin
      o_index <= index_d;
    end
  end
`endif

endmodule

// File: tb/tb_tbcm_rr_arbiter.sv
// Directed bench for tbcm_rr_arbiter (ENTRIES=4), vector table plus reset sequence.
// Checks o_index as well when TBCM_RR_ARBITER_INDEX_EN is defined.
module tb_tbcm_rr_arbiter;

  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] request;
  logic         free;
  logic [N-1:0] grant;
  logic         valid;
`ifdef TBCM_RR_ARBITER_INDEX_EN
  logic [1:0]   index;
`endif

  int total;
  int bad;

  tbcm_rr_arbiter #(.ENTRIES(N)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_request(request),
    .i_free   (free),
    .o_grant  (grant),
    .o_valid  (valid)
`ifdef TBCM_RR_ARBITER_INDEX_EN
    ,
    .o_index  (index)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic [N-1:0] req;
    logic         free;
    logic [N-1:0] exp_grant;
    logic [1:0]   exp_idx;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [N-1:0] eg, input logic [1:0] ei);
    check({name, ".grant"}, 32'(grant), 32'(eg));
    check({name, ".valid"}, 32'(valid), 32'(|eg));
`ifdef TBCM_RR_ARBITER_INDEX_EN
    check({name, ".index"}, 32'(index), 32'(ei));
`endif
  endtask

  // One-hot invariant checked at every falling edge
  always @(negedge clk) begin
    if ((grant & (grant - 1'b1)) != '0) begin
      bad++;
      $display("FAIL onehot: got %b expected at most one bit", grant);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    // rst_n, req, free, exp_grant, exp_idx
    vecs[0]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2};  // single request
    vecs[1]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2};
    vecs[2]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2};
    vecs[3]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2};
    vecs[4]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2};
    vecs[5]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 2'd2};
    vecs[6]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd2};  // release, ptr=3
    vecs[7]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd2};  // free while idle ignored
    vecs[8]  = '{1'b1, 4'b0101, 1'b0, 4'b0001, 2'd0};  // wrap from ptr 3
    vecs[9]  = '{1'b1, 4'b0101, 1'b1, 4'b0100, 2'd2};
    vecs[10] = '{1'b1, 4'b0100, 1'b1, 4'b0100, 2'd2};  // lone requester re-granted
    vecs[11] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd2};
    vecs[12] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0};  // reset, ptr=0
    vecs[13] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0};  // rotation
    vecs[14] = '{1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1};
    vecs[15] = '{1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2};
    vecs[16] = '{1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3};
    vecs[17] = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0};
    vecs[18] = '{1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1};
    vecs[19] = '{1'b1, 4'b1001, 1'b0, 4'b0010, 2'd1};  // stability
    vecs[20] = '{1'b1, 4'b1001, 1'b0, 4'b0010, 2'd1};
    vecs[21] = '{1'b1, 4'b1001, 1'b1, 4'b1000, 2'd3};
    vecs[22] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd3};  // index holds after release
    vecs[23] = '{1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0};
    vecs[24] = '{1'b1, 4'b0011, 1'b1, 4'b0010, 2'd1};
    vecs[25] = '{1'b1, 4'b0010, 1'b1, 4'b0010, 2'd1};

    rst_n   = 1'b0;
    request = '0;
    free    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      rst_n   = vecs[i].rst_n;
      request = vecs[i].req;
      free    = vecs[i].free;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_grant, vecs[i].exp_idx);
    end

    // Asynchronous reset mid-grant: grant must drop before any clock edge
    @(negedge clk);
    rst_n   = 1'b1;
    request = 4'b0000;
    free    = 1'b1;
    @(negedge clk);
    request = 4'b0100;
    free    = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("pre_rst", 4'b0100, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 4'b0000, 2'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    request = 4'b1111;
    @(posedge clk);
    #1;
    check_outputs("post_rst", 4'b0001, 2'd0);

`ifdef TBCM_RR_ARBITER_INDEX_EN
    // Index drives a binary-select mux; grant on entry 3 must route data word 3
    begin
      logic [7:0] mux_data [4];
      mux_data[0] = 8'hA0;
      mux_data[1] = 8'hB1;
      mux_data[2] = 8'hC2;
      mux_data[3] = 8'hD3;
      @(negedge clk);
      request = 4'b1000;
      free    = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("idx_grant", 4'b1000, 2'd3);
      check("mux_data", 32'(mux_data[index]), 32'h0000_00D3);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
